crypto_start_ctrl: RTL and testbench
====================================

Name: crypto_start_ctrl

Overview:
- Crypto-domain sequencer directly downstream of the USB-to-crypto pulse synchronizer; it consumes the single-cycle start pulse that synchronizer delivers.
- On each start it captures plaintext and key, waits a programmable settle delay, and launches the cipher core with a one-cycle start.
- It holds the scope trigger high for the whole encryption, captures the ciphertext, and emits a one-cycle done pulse for the return crypto-to-USB synchronizer.
- A timeout guards against a hung core.

Parameters:
pPT_WIDTH, 128, plaintext/ciphertext width
pKEY_WIDTH, 128, key width
pDLY_WIDTH, 16, settle-delay counter width
pTIMEOUT, 65535, max cycles in RUN before abort (≥2)

Ports:
crypto_clk  in  1  sole clock
crypto_rst_n  in  1  asynchronous active-low reset
start_pulse  in  1  single-cycle start, from synchronizer output
cfg_delay  in  pDLY_WIDTH  settle cycles before core_start; quasi-static, sampled at start acceptance
pt_in  in  pPT_WIDTH  plaintext, quasi-static
key_in  in  pKEY_WIDTH  key, quasi-static
core_pt  out  pPT_WIDTH  captured plaintext to core
core_key  out  pKEY_WIDTH  captured key to core
core_start  out  1  one-cycle core launch
core_done  in  1  one-cycle core completion
core_ct  in  pPT_WIDTH  core result, valid with core_done
ct_out  out  pPT_WIDTH  captured ciphertext
done_pulse  out  1  one-cycle completion, to return synchronizer
busy  out  1  high from acceptance through DONE
trigger  out  1  scope trigger
timeout_err  out  1  last run aborted by timeout

Behaviour:
- All outputs are registered; no combinational input-to-output path.
- Reset, asynchronous on crypto_rst_n low, at any time including mid-run:
  - state = IDLE.
  - core_start, done_pulse, busy, trigger, timeout_err = 0.
  - core_pt, core_key, ct_out = 0.
  - Counters = 0.
- States: IDLE, DELAY, START, RUN, DONE.
- IDLE:
  - start_pulse high at edge T: capture core_pt←pt_in, core_key←key_in; cnt←cfg_delay; timeout_err←0; busy←1; state←DELAY.
- DELAY:
  - cnt==0 → state←START, core_start←1, trigger←1.
  - Otherwise cnt←cnt−1.
  - With delay D, core_start and trigger are high for the cycle after edge T+1+D. D=0 gives core_start after edge T+1.
- START:
  - Lasts exactly one cycle: core_start←0, timer←0, state←RUN.
  - core_done seen during START is ignored.
- RUN, on each edge:
  - core_done=1 → ct_out←core_ct, trigger←0, state←DONE, done_pulse←1.
  - Else if timer==pTIMEOUT−1 → timeout_err←1, trigger←0, ct_out unchanged, state←DONE, done_pulse←1.
  - Else timer←timer+1.
  - core_done and timeout on the same edge: done wins, timeout_err stays 0.
- DONE:
  - Lasts one cycle: done_pulse←0, busy←0, state←IDLE.
  - A new start is accepted from the next edge.
- start_pulse while state≠IDLE is dropped; no queuing.
- core_done outside RUN is ignored.
- cfg_delay, pt_in and key_in changes after acceptance do not affect the current run.
- Counter arithmetic is unsigned, no wrap.
  - Delay counter stops at 0.
  - Timer width is clog2(pTIMEOUT+1) and saturates via the compare.
- Trigger behaviour:
  - Rises in the core_start cycle.
  - Falls on the edge that captures core_done.
  - Trigger-high duration equals core latency + 1 cycle.

Decomposition:
- params.vh (shared header): default widths (pPT_WIDTH, pKEY_WIDTH, pDLY_WIDTH) and pTIMEOUT as defines.
- State encoding is local to this module.
- One natural sub-module: crypto_cycle_counter, a loadable down-counter with zero flag, width-parameterized, async active-low reset. It serves the settle delay.
- The timeout counter is inline.

Test Plan:
- Reset, then cfg_delay=0, start_pulse at edge T, core_done 10 cycles after core_start with core_ct=0xA5…A5:
  - core_start high after edge T+1.
  - trigger high exactly 11 cycles.
  - ct_out=0xA5…A5.
  - done_pulse one cycle.
  - busy falls one cycle after done_pulse.
- cfg_delay=5 → core_start after edge T+6; core_pt/core_key equal pt_in/key_in at T even though pt_in is changed at T+2.
- start_pulse repeated at T+3 and during RUN:
  - Both ignored.
  - Exactly one core_start.
  - Exactly one done_pulse.
- pTIMEOUT=8 bench build with core_done never asserted:
  - trigger falls after 8 RUN cycles.
  - timeout_err=1, ct_out unchanged, done_pulse once.
  - Next start clears timeout_err.
- core_done on the exact timeout edge → ct_out captured, timeout_err=0.
- crypto_rst_n low asynchronously mid-RUN with trigger high:
  - All outputs 0 immediately, without a clock edge.
  - After release, IDLE accepts a new start normally.

Source files
------------

// File: rtl/crypto_start_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// crypto_start_ctrl_pkg
//   Shared defaults for the crypto start sequencer and its core interface:
//   datapath widths, settle-delay counter width and the RUN timeout, plus a
//   helper that sizes the timeout timer.
// ---------------------------------------------------------------------------
package crypto_start_ctrl_pkg;

   localparam int PT_WIDTH_DEF  = 128;
   localparam int KEY_WIDTH_DEF = 128;
   localparam int DLY_WIDTH_DEF = 16;
   localparam int TIMEOUT_DEF   = 65535;

   // Timer must hold every value up to and including the timeout limit.
   function automatic int timer_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/crypto_start_ctrl_if.sv
// ---------------------------------------------------------------------------
// crypto_start_ctrl_if
//   Handshake between the start sequencer (master) and the cipher core
//   (slave).
//   core_pt / core_key : operands held stable for the whole encryption
//   core_start         : one-cycle launch
//   core_done          : one-cycle completion from the core
//   core_ct            : ciphertext, valid with core_done
// ---------------------------------------------------------------------------
interface crypto_start_ctrl_if
   import crypto_start_ctrl_pkg::*;
#(
   parameter int pPT_WIDTH  = PT_WIDTH_DEF,
   parameter int pKEY_WIDTH = KEY_WIDTH_DEF
);

   logic [pPT_WIDTH-1:0]  core_pt;
   logic [pKEY_WIDTH-1:0] core_key;
   logic                  core_start;
   logic                  core_done;
   logic [pPT_WIDTH-1:0]  core_ct;

   modport master (
      output core_pt,
      output core_key,
      output core_start,
      input  core_done,
      input  core_ct
   );

   modport slave (
      input  core_pt,
      input  core_key,
      input  core_start,
      output core_done,
      output core_ct
   );

endinterface

// File: rtl/crypto_start_ctrl_cycle_counter.sv
// ---------------------------------------------------------------------------
// crypto_cycle_counter
//   Loadable down-counter that stops at zero; used for the settle delay.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one unless already zero
//   zero       : count is zero
// ---------------------------------------------------------------------------
module crypto_cycle_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop in the
   // design samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/crypto_start_ctrl.sv
// ---------------------------------------------------------------------------
// crypto_start_ctrl
//   Crypto-domain sequencer. On a synchronised start pulse it captures
//   plaintext and key, waits cfg_delay settle cycles, launches the cipher
//   core for one cycle, holds the scope trigger for the whole encryption,
//   captures the ciphertext and emits a one-cycle done pulse. A timer aborts
//   a run whose core never answers.
//
//   crypto_clk, crypto_rst_n : clock, asynchronous active-low reset
//   start_pulse              : one-cycle start (dropped unless idle)
//   cfg_delay                : settle cycles, sampled at acceptance
//   pt_in, key_in            : operands, sampled at acceptance
//   core                     : master side of the cipher core handshake
//   ct_out                   : last captured ciphertext
//   done_pulse               : one-cycle completion
//   busy                     : acceptance through DONE
//   trigger                  : scope trigger, core_start cycle to capture
//   timeout_err              : last run aborted by timeout
// ---------------------------------------------------------------------------
module crypto_start_ctrl
   import crypto_start_ctrl_pkg::*;
#(
   parameter int pPT_WIDTH  = PT_WIDTH_DEF,
   parameter int pKEY_WIDTH = KEY_WIDTH_DEF,
   parameter int pDLY_WIDTH = DLY_WIDTH_DEF,
   parameter int pTIMEOUT   = TIMEOUT_DEF
) (
   input  logic                  crypto_clk,
   input  logic                  crypto_rst_n,
   input  logic                  start_pulse,
   input  logic [pDLY_WIDTH-1:0] cfg_delay,
   input  logic [pPT_WIDTH-1:0]  pt_in,
   input  logic [pKEY_WIDTH-1:0] key_in,
   crypto_start_ctrl_if.master   core,
   output logic [pPT_WIDTH-1:0]  ct_out,
   output logic                  done_pulse,
   output logic                  busy,
   output logic                  trigger,
   output logic                  timeout_err
);

   localparam int                TIMER_W    = timer_width(pTIMEOUT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(pTIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_START,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state;
   logic [pPT_WIDTH-1:0]  pt_reg;
   logic [pKEY_WIDTH-1:0] key_reg;
   logic                  start_reg;
   logic [TIMER_W-1:0]    timer;

   logic dly_load;
   logic dly_dec;
   logic dly_zero;

   // The counter is loaded on the acceptance edge and counts down while in
   // DELAY; DELAY exits on the first edge that finds it at zero.
   assign dly_load = (state == S_IDLE) && start_pulse;
   assign dly_dec  = (state == S_DELAY);

   crypto_cycle_counter #(
      .WIDTH (pDLY_WIDTH)
   ) u_dly_cnt (
      .clk      (crypto_clk),
      .rst_n    (crypto_rst_n),
      .load     (dly_load),
      .load_val (cfg_delay),
      .dec      (dly_dec),
      .zero     (dly_zero)
   );

   assign core.core_pt    = pt_reg;
   assign core.core_key   = key_reg;
   assign core.core_start = start_reg;

   always_ff @(posedge crypto_clk or negedge crypto_rst_n) begin
      if (!crypto_rst_n) begin
         state       <= S_IDLE;
         pt_reg      <= '0;
         key_reg     <= '0;
         start_reg   <= 1'b0;
         timer       <= '0;
         ct_out      <= '0;
         done_pulse  <= 1'b0;
         busy        <= 1'b0;
         trigger     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_pulse) begin
                  pt_reg      <= pt_in;
                  key_reg     <= key_in;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_DELAY;
               end
            end
            S_DELAY: begin
               if (dly_zero) begin
                  start_reg <= 1'b1;
                  trigger   <= 1'b1;
                  state     <= S_START;
               end
            end
            S_START: begin
               start_reg <= 1'b0;
               timer     <= '0;
               state     <= S_RUN;
            end
            S_RUN: begin
               // A completion on the timeout edge still counts as success.
               if (core.core_done) begin
                  ct_out     <= core.core_ct;
                  trigger    <= 1'b0;
                  done_pulse <= 1'b1;
                  state      <= S_DONE;
               end else if (timer == TIMER_LAST) begin
                  timeout_err <= 1'b1;
                  trigger     <= 1'b0;
                  done_pulse  <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: begin
               done_pulse <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            // NOTE: the unused state codes recover to IDLE instead of
            // leaving the FSM stranded after an upset.
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_start_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crypto_start_ctrl
//   dut_a: long timeout (20) for normal runs; dut_b: timeout 8 for the abort
//   cases. Host inputs other than start_pulse are shared; each DUT has its
//   own start and core handshake. 'sel' picks which DUT the tasks act on.
// ---------------------------------------------------------------------------
module tb_crypto_start_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_a, start_b;
   logic [15:0]  cfg_delay;
   logic [127:0] pt_in, key_in;

   logic [127:0] a_ct_out, b_ct_out;
   logic         a_done_pulse, a_busy, a_trigger, a_timeout_err;
   logic         b_done_pulse, b_busy, b_trigger, b_timeout_err;

   crypto_start_ctrl_if #(.pPT_WIDTH(128), .pKEY_WIDTH(128)) if_a ();
   crypto_start_ctrl_if #(.pPT_WIDTH(128), .pKEY_WIDTH(128)) if_b ();

   crypto_start_ctrl #(
      .pPT_WIDTH(128), .pKEY_WIDTH(128), .pDLY_WIDTH(16), .pTIMEOUT(20)
   ) dut_a (
      .crypto_clk   (clk),
      .crypto_rst_n (rst_n),
      .start_pulse  (start_a),
      .cfg_delay    (cfg_delay),
      .pt_in        (pt_in),
      .key_in       (key_in),
      .core         (if_a.master),
      .ct_out       (a_ct_out),
      .done_pulse   (a_done_pulse),
      .busy         (a_busy),
      .trigger      (a_trigger),
      .timeout_err  (a_timeout_err)
   );

   crypto_start_ctrl #(
      .pPT_WIDTH(128), .pKEY_WIDTH(128), .pDLY_WIDTH(16), .pTIMEOUT(8)
   ) dut_b (
      .crypto_clk   (clk),
      .crypto_rst_n (rst_n),
      .start_pulse  (start_b),
      .cfg_delay    (cfg_delay),
      .pt_in        (pt_in),
      .key_in       (key_in),
      .core         (if_b.master),
      .ct_out       (b_ct_out),
      .done_pulse   (b_done_pulse),
      .busy         (b_busy),
      .trigger      (b_trigger),
      .timeout_err  (b_timeout_err)
   );

   always #5 clk = ~clk;

   // View of the selected DUT.
   bit           sel;
   logic         v_core_start, v_done_pulse, v_busy, v_trigger, v_timeout_err;
   logic [127:0] v_core_pt, v_core_key, v_ct_out;

   assign v_core_start  = sel ? if_b.core_start : if_a.core_start;
   assign v_core_pt     = sel ? if_b.core_pt    : if_a.core_pt;
   assign v_core_key    = sel ? if_b.core_key   : if_a.core_key;
   assign v_ct_out      = sel ? b_ct_out        : a_ct_out;
   assign v_done_pulse  = sel ? b_done_pulse    : a_done_pulse;
   assign v_busy        = sel ? b_busy          : a_busy;
   assign v_trigger     = sel ? b_trigger       : a_trigger;
   assign v_timeout_err = sel ? b_timeout_err   : a_timeout_err;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s (dut_%s): got %h, expected %h", name, sel ? "b" : "a", act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   task automatic drive_done(input logic v, input logic [127:0] ct);
      if (sel) begin
         if_b.core_done = v;
         if_b.core_ct   = ct;
      end else begin
         if_a.core_done = v;
         if_a.core_ct   = ct;
      end
   endtask

   // One full transaction. lat = cycles from core_start to core_done
   // (negative: core never answers). extra = fire ignored starts in DELAY
   // and in RUN.
   task automatic run_txn(input int delay, input int lat,
                          input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] ct, input bit extra,
                          input int exp_start, input int exp_trig,
                          input bit exp_to, input logic [127:0] exp_ct);
      int n, trig, starts, dones;
      bit fell;
      @(negedge clk);
      cfg_delay = 16'(delay);
      pt_in     = pt;
      key_in    = key;
      drive_start(1'b1);
      @(posedge clk); #1;   // edge T
      check("accept_busy", v_busy, 1);
      check("accept_clears_timeout", v_timeout_err, 0);
      @(negedge clk);
      drive_start(1'b0);

      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;  // edge T+i
         if (i == 2) begin
            pt_in     = ~pt;
            key_in    = ~key;
            cfg_delay = 16'(delay + 7);
            if (extra) drive_start(1'b1);
         end else if (i == 3) begin
            drive_start(1'b0);
         end
         if (v_core_start) begin
            n = i;
            break;
         end
      end
      drive_start(1'b0);
      check("core_start_edge", n, exp_start);
      check("trigger_rises", v_trigger, 1);
      check("core_pt_held", v_core_pt, pt);
      check("core_key_held", v_core_key, key);

      trig   = 1;
      starts = 1;
      fell   = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         drive_done(1'b0, ct);
         if (extra && k == 3) drive_start(1'b1);
         if (extra && k == 4) drive_start(1'b0);
         starts += int'(v_core_start);
         if (!v_trigger) begin
            fell = 1'b1;
            break;
         end
         trig++;
         if (k == lat) drive_done(1'b1, ct);
      end
      drive_start(1'b0);
      drive_done(1'b0, ct);
      check("trigger_falls", fell, 1);
      check("trigger_cycles", trig, exp_trig);
      check("done_pulse_high", v_done_pulse, 1);
      check("ct_out", v_ct_out, exp_ct);
      check("timeout_err", v_timeout_err, exp_to);
      check("busy_in_done", v_busy, 1);
      dones = 1;

      @(posedge clk); #1;
      check("done_pulse_one_cycle", v_done_pulse, 0);
      check("busy_falls", v_busy, 0);
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         starts += int'(v_core_start);
         dones  += int'(v_done_pulse);
      end
      check("single_core_start", starts, 1);
      check("single_done_pulse", dones, 1);
   endtask

   typedef struct {
      int           delay;
      int           lat;
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] ct;
      bit           extra;
      int           exp_start;
      int           exp_trig;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [127:0] b_ct_prev;

      // delay, latency, pt, key, ct, extra starts, core_start edge, trigger cycles
      vecs[0] = '{0,  10, {16{8'h11}}, {16{8'h22}}, {16{8'hA5}}, 1'b0, 1,  11};
      vecs[1] = '{5,  3,  {16{8'h3C}}, {16{8'hC3}}, {16{8'h5A}}, 1'b0, 6,  4};
      vecs[2] = '{5,  6,  {16{8'h01}}, {16{8'h80}}, {16{8'h7E}}, 1'b1, 6,  7};
      vecs[3] = '{2,  1,  {16{8'hF0}}, {16{8'h0F}}, {16{8'h99}}, 1'b0, 3,  2};
      // Core answers on the timeout edge of dut_a (timeout 20).
      vecs[4] = '{0,  20, {16{8'h44}}, {16{8'h55}}, {16{8'h66}}, 1'b0, 1,  21};

      rst_n     = 1'b0;
      start_a   = 1'b0;
      start_b   = 1'b0;
      cfg_delay = '0;
      pt_in     = '0;
      key_in    = '0;
      if_a.core_done = 1'b0;
      if_a.core_ct   = '0;
      if_b.core_done = 1'b0;
      if_b.core_ct   = '0;
      sel = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("reset_ctrl", {v_core_start, v_done_pulse, v_busy, v_trigger, v_timeout_err}, 0);
         check("reset_core_pt", v_core_pt, 0);
         check("reset_ct_out", v_ct_out, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      sel = 1'b0;
      for (int v = 0; v < 5; v++) begin
         run_txn(vecs[v].delay, vecs[v].lat, vecs[v].pt, vecs[v].key, vecs[v].ct,
                 vecs[v].extra, vecs[v].exp_start, vecs[v].exp_trig, 1'b0, vecs[v].ct);
      end

      // Timeout build (dut_b): good run, hung core, then done on timeout edge.
      sel = 1'b1;
      b_ct_prev = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      run_txn(1, 4, {16{8'hAA}}, {16{8'hBB}}, b_ct_prev, 1'b0, 2, 5, 1'b0, b_ct_prev);
      run_txn(0, -1, {16{8'hCC}}, {16{8'hDD}}, {16{8'hEE}}, 1'b0, 1, 9, 1'b1, b_ct_prev);
      run_txn(0, 8, {16{8'h12}}, {16{8'h34}}, {16{8'h56}}, 1'b0, 1, 9, 1'b0, {16{8'h56}});

      // Asynchronous reset in the middle of RUN on dut_a.
      sel = 1'b0;
      @(negedge clk);
      cfg_delay = '0;
      pt_in     = {16{8'h77}};
      key_in    = {16{8'h88}};
      drive_start(1'b1);
      @(posedge clk);
      @(negedge clk);
      drive_start(1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("pre_reset_trigger", v_trigger, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_ctrl", {v_core_start, v_done_pulse, v_busy, v_trigger, v_timeout_err}, 0);
      check("async_reset_core_pt", v_core_pt, 0);
      check("async_reset_core_key", v_core_key, 0);
      check("async_reset_ct_out", v_ct_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(vecs[0].delay, vecs[0].lat, vecs[0].pt, vecs[0].key, vecs[0].ct,
              1'b0, vecs[0].exp_start, vecs[0].exp_trig, 1'b0, vecs[0].ct);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
